axis_img_source: RTL
====================

// Module: axis_img_source
// PURPOSE
//  AXI4-Stream frame source feeding the upsampler's s_axis input port.
//  On a start pulse it streams one SRC_IMG_WIDTH x SRC_IMG_HEIGHT frame.
//  Pixels are read from a linear pixel memory with 1-cycle read latency, raster order.
//  Output is framed with tuser on start-of-frame and tlast on end-of-row.
//  A 4-entry output FIFO absorbs backpressure and sustains 1 pixel/clk.
// PARAMETERS
//  AXISIN_DATA_WIDTH  24   pixel width on stream and memory (RGB888)
//  SRC_IMG_WIDTH      960  pixels per row
//  SRC_IMG_HEIGHT     540  rows per frame
//  MEM_ADDR_WIDTH     20   pixel memory address width (must hold W*H-1)
// PORTS
//  clk            in   1     clock
//  rst            in   1     synchronous active-high reset
//  start          in   1     1-cycle frame start request
//  base_addr      in   MEM_ADDR_WIDTH  frame base address, sampled with start
//  busy           out  1     frame in progress
//  done           out  1     1-cycle pulse after last pixel accepted
//  mem_rd_en      out  1     pixel memory read strobe
//  mem_rd_addr    out  MEM_ADDR_WIDTH  read address
//  mem_rd_data    in   AXISIN_DATA_WIDTH  read data, valid cycle after mem_rd_en
//  m_axis_tvalid  out  1     stream valid
//  m_axis_tready  in   1     stream ready
//  m_axis_tdata   out  AXISIN_DATA_WIDTH  pixel
//  m_axis_tkeep   out  AXISIN_DATA_WIDTH/8  all ones
//  m_axis_tstrb   out  AXISIN_DATA_WIDTH/8  all ones
//  m_axis_tlast   out  1     last pixel of a row
//  m_axis_tuser   out  1     first pixel of the frame
//  m_axis_tid     out  1     tied 0
//  m_axis_tdest   out  1     tied 0
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, mem_rd_en, m_axis_tvalid, tlast, tuser = 0.
//  Reset also clears mem_rd_addr, tdata, FIFO, counters and in-flight flag.
//  FSM IDLE: start=1 -> latch base_addr, clear x/y counters, go RUN.
//    start is ignored in any state other than IDLE.
//  FSM RUN: issue reads; after the read of pixel (W-1,H-1) go DRAIN.
//  FSM DRAIN: wait for the last pixel handshake (tlast & tuser tags drained) -> DONE.
//  FSM DONE: done=1 for one cycle, then IDLE. busy=1 in RUN/DRAIN/DONE.
//  Read issue: mem_rd_en=1 in RUN when fifo_count + inflight < 4 (registered values).
//    One read per cycle max. addr = base + y*W + x, computed incrementally.
//    x wraps at W-1 and increments y. No address wrap beyond MEM_ADDR_WIDTH is checked.
//  Tags: at issue time eol=(x==W-1) and sof=(x==0&&y==0) are piped with the read.
//    Tags are written into the FIFO together with mem_rd_data.
//  FIFO: 4 x {sof,eol,data}; write on inflight, pop on tvalid&tready.
//    Simultaneous write and pop keeps the count unchanged.
//  Handshake: tvalid = FIFO non-empty; head data/tags stable while tvalid&!tready.
//    tvalid never drops without a handshake.
//  Latency: start at edge T -> rd_en in cycle T+1 -> FIFO write end of T+2.
//    First tvalid is seen in cycle T+3.
//  Throughput: tready held 1 -> one beat per clock after first tvalid, no bubbles.
//  Backpressure: issue stalls when 4 entries are occupied or in flight.
//    No read is ever dropped or duplicated.
//  done: asserted the cycle after the handshake of the final (W*H-th) beat.
//  Reset mid-frame: immediate return to IDLE, FIFO flushed, tvalid=0 next cycle.
//    Any in-flight read data is discarded.
// TESTING (W=4, H=2, mem[i]=i+0x100, base=0)
//  1 start, tready=1 -> 8 beats 0x100..0x107 on consecutive cycles.
//    tuser on beat 0; tlast on beats 3 and 7; done 1 cycle after beat 7.
//  2 tready toggling 1/0 each cycle -> same 8 beats in order.
//    Data and tags held stable while stalled; no loss or duplicate.
//  3 tready=0 for 20 cycles after start -> exactly 4 reads issued.
//    tvalid=1 with tdata=0x100; mem_rd_en=0 until tready rises.
//  4 start pulses during busy -> ignored; a single 8-beat frame and a single done.
//  5 rst during beat 5 -> tvalid=0, busy=0 next cycle.
//    A new start produces a full frame from 0x100 with tuser.
//  6 base_addr=0x10 -> beats carry mem[0x10..0x17].

Source files
------------

// File: rtl/axis_img_source.sv
// AXI4-Stream frame source: raster-reads one frame from a 1-cycle-latency pixel memory
// and streams it with tuser on start-of-frame and tlast on end-of-row through a 4-deep FIFO.
module axis_img_source #(
  parameter int AXISIN_DATA_WIDTH = 24,
  parameter int SRC_IMG_WIDTH     = 960,
  parameter int SRC_IMG_HEIGHT    = 540,
  parameter int MEM_ADDR_WIDTH    = 20
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [MEM_ADDR_WIDTH-1:0]      base_addr,
  output logic                           busy,
  output logic                           done,
  output logic                           mem_rd_en,
  output logic [MEM_ADDR_WIDTH-1:0]      mem_rd_addr,
  input  logic [AXISIN_DATA_WIDTH-1:0]   mem_rd_data,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [AXISIN_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [AXISIN_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [AXISIN_DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tuser,
  output logic                           m_axis_tid,
  output logic                           m_axis_tdest
);

  localparam int XW = (SRC_IMG_WIDTH > 1) ? $clog2(SRC_IMG_WIDTH) : 1;
  localparam int YW = (SRC_IMG_HEIGHT > 1) ? $clog2(SRC_IMG_HEIGHT) : 1;
  localparam int FW = AXISIN_DATA_WIDTH + 2;
  localparam logic [XW-1:0] X_LAST = XW'(SRC_IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(SRC_IMG_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                    state_reg;
  logic [XW-1:0]             x_reg;
  logic [YW-1:0]             y_reg;
  logic [MEM_ADDR_WIDTH-1:0] addr_reg;
  logic                      inflight_reg;
  logic                      infl_sof_reg;
  logic                      infl_eol_reg;
  logic [FW-1:0]             fifo_mem [4];
  logic [1:0]                wr_ptr_reg;
  logic [1:0]                rd_ptr_reg;
  logic [2:0]                count_reg;

  logic          issue;
  logic          push;
  logic          pop;
  logic [FW-1:0] head;

  // Reserve a FIFO slot for every outstanding read so returning data can never overflow it.
  assign issue = (state_reg == RUN) && (({1'b0, count_reg} + {3'b000, inflight_reg}) < 4'd4);
  assign push  = inflight_reg;
  assign pop   = m_axis_tvalid && m_axis_tready;
  assign head  = fifo_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      x_reg        <= '0;
      y_reg        <= '0;
      addr_reg     <= '0;
      inflight_reg <= 1'b0;
      infl_sof_reg <= 1'b0;
      infl_eol_reg <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
    end else begin
      inflight_reg <= issue;
      if (issue) begin
        infl_sof_reg <= (x_reg == '0) && (y_reg == '0);
        infl_eol_reg <= (x_reg == X_LAST);
      end

      if (push) begin
        fifo_mem[wr_ptr_reg] <= {infl_sof_reg, infl_eol_reg, mem_rd_data};
        wr_ptr_reg           <= wr_ptr_reg + 2'd1;
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + 2'd1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 3'd1;
        2'b01:   count_reg <= count_reg - 3'd1;
        default: count_reg <= count_reg;
      endcase

      case (state_reg)
        IDLE: begin
          if (start) begin
            addr_reg  <= base_addr;
            x_reg     <= '0;
            y_reg     <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (issue) begin
            addr_reg <= addr_reg + MEM_ADDR_WIDTH'(1);
            if (x_reg == X_LAST) begin
              x_reg <= '0;
              if (y_reg == Y_LAST) begin
                y_reg     <= '0;
                state_reg <= DRAIN;
              end else begin
                y_reg <= y_reg + YW'(1);
              end
            end else begin
              x_reg <= x_reg + XW'(1);
            end
          end
        end
        // All reads are issued, so popping the only remaining item is the final beat.
        DRAIN: begin
          if (pop && (count_reg == 3'd1) && !inflight_reg) state_reg <= DONE;
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy          = (state_reg != IDLE);
  assign done          = (state_reg == DONE);
  assign mem_rd_en     = issue;
  assign mem_rd_addr   = addr_reg;
  assign m_axis_tvalid = (count_reg != 3'd0);
  assign m_axis_tdata  = head[AXISIN_DATA_WIDTH-1:0];
  assign m_axis_tlast  = head[AXISIN_DATA_WIDTH];
  assign m_axis_tuser  = head[AXISIN_DATA_WIDTH+1];
  assign m_axis_tkeep  = '1;
  assign m_axis_tstrb  = '1;
  assign m_axis_tid    = 1'b0;
  assign m_axis_tdest  = 1'b0;

endmodule
